inst_sequencer: RTL and testbench

Upstream control stage for the 8-bit datapath. It fetches 16-bit instructions from program memory over a req/ack handshake and holds each one in an instruction register (IR). It presents the IR on inst and pulses alu_en for one execute cycle on ALU-class words. It also resolves jumps against the flag inputs, advances the PC, and halts on the HLT opcode.

---
 rtl/seq_pkg.sv | 40 ++++
 rtl/inst_sequencer_if.sv | 27 ++
 rtl/seq_branch_unit.sv | 37 +++
 rtl/inst_sequencer.sv | 164 ++++++++++++++++
 tb/tb_inst_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, instruction
// class codes, the HLT opcode, jump condition codes and the fetch timeout limit.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Instruction class, inst[15:14]
  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_RSV = 2'b01;
  localparam logic [1:0] CLS_JMP = 2'b10;
  localparam logic [1:0] CLS_SYS = 2'b11;

  // System opcode field inst[13:10] that halts the sequencer
  localparam logic [3:0] HLT_OP = 4'b1111;

  // Jump condition field inst[13:12]
  localparam logic [1:0] JC_ALWAYS = 2'b00;
  localparam logic [1:0] JC_Z      = 2'b01;
  localparam logic [1:0] JC_C      = 2'b10;
  localparam logic [1:0] JC_NZ     = 2'b11;

  // Consecutive ack-less FETCH cycles tolerated when the timeout is built in
  localparam int unsigned FETCH_TIMEOUT = 16;
  localparam int unsigned TO_CNT_W      = $clog2(FETCH_TIMEOUT);

  function automatic logic [1:0] inst_class(input logic [15:0] w);
    return w[15:14];
  endfunction

  function automatic logic is_hlt(input logic [15:0] w);
    return (w[15:14] == CLS_SYS) && (w[13:10] == HLT_OP);
  endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Program memory read port: the sequencer is the master issuing pm_req/pm_addr,
// program memory is the slave returning pm_ack/pm_data.
interface inst_sequencer_if #(
  parameter int PC_W   = 8,
  parameter int INST_W = 16
);

  logic              pm_req;
  logic [PC_W-1:0]   pm_addr;
  logic              pm_ack;
  logic [INST_W-1:0] pm_data;

  modport master (
    output pm_req,
    output pm_addr,
    input  pm_ack,
    input  pm_data
  );

  modport slave (
    input  pm_req,
    input  pm_addr,
    output pm_ack,
    output pm_data
  );

endinterface

// File: rtl/seq_branch_unit.sv
// Combinational jump resolution: decides whether the IR is a taken jump given
// the current flags and produces the PC for the next fetch.
module seq_branch_unit
  import seq_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int INST_W = 16
) (
  input  logic [INST_W-1:0] ir,
  input  logic              flag_z,
  input  logic              flag_c,
  input  logic [PC_W-1:0]   pc,
  output logic              taken,
  output logic [PC_W-1:0]   next_pc
);

  logic cond_met;
  // Only the condition field, class and target bits matter here
  logic unused_ir_fold;

  assign unused_ir_fold = ^ir;

  // Evaluate the jump condition and select target or sequential successor
  always_comb begin
    cond_met = 1'b0;
    case (ir[13:12])
      JC_ALWAYS: cond_met = 1'b1;
      JC_Z:      cond_met = flag_z;
      JC_C:      cond_met = flag_c;
      JC_NZ:     cond_met = ~flag_z;
      default:   cond_met = 1'b0;
    endcase
    taken   = (inst_class(ir) == CLS_JMP) && cond_met;
    next_pc = taken ? ir[PC_W-1:0] : pc + PC_W'(1);
  end

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: fetches 16-bit words over the pm_* handshake into the
// IR, strobes alu_en for one cycle on ALU-class words, resolves jumps against
// the flags, advances the PC and halts on HLT.
// Optional build macro SEQ_FETCH_TIMEOUT_EN adds a sticky fetch_fault output
// and halts after FETCH_TIMEOUT consecutive ack-less FETCH cycles.
module inst_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  inst_sequencer_if.master   pm,
  output logic [INST_W-1:0]  inst,
  output logic               alu_en,
  input  logic               flag_z,
  input  logic               flag_c,
  output logic [PC_W-1:0]    pc,
  output logic               halted
`ifdef SEQ_FETCH_TIMEOUT_EN
  ,
  output logic               fetch_fault
`endif
);

  state_t            state_q,  state_d;
  logic [PC_W-1:0]   pc_q,     pc_d;
  logic [INST_W-1:0] ir_q,     ir_d;
  logic              pm_req_q, pm_req_d;
  logic              alu_en_q, alu_en_d;
  logic              halted_q, halted_d;

`ifdef SEQ_FETCH_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                fault_q,  fault_d;
`endif

  logic            br_taken;
  logic [PC_W-1:0] br_next_pc;

  seq_branch_unit #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_branch (
    .ir      (ir_q),
    .flag_z  (flag_z),
    .flag_c  (flag_c),
    .pc      (pc_q),
    .taken   (br_taken),
    .next_pc (br_next_pc)
  );

  // Next-state and next-output computation; outputs are registered so every
  // strobe lines up with the state it belongs to
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    pm_req_d = 1'b0;
    alu_en_d = 1'b0;
    halted_d = halted_q;
`ifdef SEQ_FETCH_TIMEOUT_EN
    to_cnt_d = '0;
    fault_d  = fault_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d  = ST_FETCH;
          pm_req_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (pm.pm_ack) begin
          ir_d    = pm.pm_data;
          state_d = ST_DECODE;
        end else begin
          pm_req_d = 1'b1;
`ifdef SEQ_FETCH_TIMEOUT_EN
          if (to_cnt_q == TO_CNT_W'(FETCH_TIMEOUT - 1)) begin
            pm_req_d = 1'b0;
            fault_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            to_cnt_d = to_cnt_q + TO_CNT_W'(1);
          end
`endif
        end
      end
      ST_DECODE: begin
        // alu_en held low here so operand muxes settle on the new IR
        if (is_hlt(ir_q)) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          state_d = ST_EXEC;
          case (inst_class(ir_q))
            CLS_ALU:                   alu_en_d = 1'b1;
            CLS_RSV, CLS_JMP, CLS_SYS: alu_en_d = 1'b0;
            default:                   alu_en_d = 1'b0;
          endcase
        end
      end
      ST_EXEC: begin
        // run is only honoured here, so the current instruction always retires
        pc_d = br_next_pc;
        if (run) begin
          state_d  = ST_FETCH;
          pm_req_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset drops pm_req at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      pm_req_q <= 1'b0;
      alu_en_q <= 1'b0;
      halted_q <= 1'b0;
`ifdef SEQ_FETCH_TIMEOUT_EN
      to_cnt_q <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      pm_req_q <= pm_req_d;
      alu_en_q <= alu_en_d;
      halted_q <= halted_d;
`ifdef SEQ_FETCH_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      fault_q  <= fault_d;
`endif
    end
  end

  assign pm.pm_req  = pm_req_q;
  assign pm.pm_addr = pc_q;
  assign inst       = ir_q;
  assign alu_en     = alu_en_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
`ifdef SEQ_FETCH_TIMEOUT_EN
  assign fetch_fault = fault_q;
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: directed program steps plus a
// randomized instruction stream checked against an architectural PC model.
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        flag_z;
  logic        flag_c;
  logic [15:0] inst;
  logic        alu_en;
  logic [7:0]  pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_pc;
  logic [15:0] last_ir;

  always #5 clk = ~clk;

  inst_sequencer_if #(.PC_W(8), .INST_W(16)) pm_if ();

  inst_sequencer #(
    .PC_W     (8),
    .INST_W   (16),
    .RESET_PC (8'h00)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .pm     (pm_if),
    .inst   (inst),
    .alu_en (alu_en),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .pc     (pc),
    .halted (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural successor PC from the ISA rules
  function automatic logic [7:0] ref_next_pc(input logic [7:0] cur, input logic [15:0] w,
                                             input bit fz, input bit fc);
    bit is_jump;
    bit take;
    is_jump = (w[15:14] == 2'b10);
    take = (w[13:12] == 2'd0) ||
           (w[13:12] == 2'd1 && fz) ||
           (w[13:12] == 2'd2 && fc) ||
           (w[13:12] == 2'd3 && !fz);
    if (is_jump && take) return w[7:0];
    return 8'((int'(cur) + 1) % 256);
  endfunction

  // One instruction: wait for FETCH, answer after 'delay' cycles, then check
  // DECODE and EXEC (or HALT) behaviour and advance the model PC.
  task automatic run_instr(input logic [15:0] w, input int delay, input bit fz, input bit fc);
    int  waits;
    bit  hlt;
    waits = 0;
    hlt   = (w[15:10] == 6'b111111);
    do begin
      @(negedge clk);
      waits++;
    end while (pm_if.pm_req !== 1'b1 && waits < 8);
    chk("fetch_lat", waits, 1);
    if (pm_if.pm_req !== 1'b1) return;
    chk("fetch_addr", pm_if.pm_addr, exp_pc);
    chk("fetch_pc", pc, exp_pc);
    for (int d = 0; d < delay; d++) begin
      pm_if.pm_ack  = 1'b0;
      pm_if.pm_data = 16'($urandom);
      @(negedge clk);
      chk("wait_req", pm_if.pm_req, 1'b1);
      chk("wait_addr", pm_if.pm_addr, exp_pc);
      chk("wait_alu_en", alu_en, 1'b0);
      chk("wait_ir", inst, last_ir);
    end
    pm_if.pm_ack  = 1'b1;
    pm_if.pm_data = w;
    flag_z        = fz;
    flag_c        = fc;
    @(negedge clk);
    chk("dec_ir", inst, w);
    chk("dec_alu_en", alu_en, 1'b0);
    chk("dec_req", pm_if.pm_req, 1'b0);
    // Stray ack with junk data while not fetching must be ignored
    pm_if.pm_data = ~w;
    @(negedge clk);
    last_ir = w;
    if (hlt) begin
      chk("hlt_halted", halted, 1'b1);
      chk("hlt_req", pm_if.pm_req, 1'b0);
      chk("hlt_alu_en", alu_en, 1'b0);
    end else begin
      chk("exec_alu_en", alu_en, (w[15:14] == 2'b00));
      chk("exec_ir", inst, w);
      chk("exec_halted", halted, 1'b0);
      exp_pc = ref_next_pc(exp_pc, w, fz, fc);
    end
    pm_if.pm_ack = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [15:0] w;
    rst_n         = 1'b0;
    run           = 1'b0;
    flag_z        = 1'b0;
    flag_c        = 1'b0;
    pm_if.pm_ack  = 1'b0;
    pm_if.pm_data = 16'h0000;
    exp_pc        = 8'h00;
    last_ir       = 16'h0000;

    repeat (2) @(negedge clk);
    chk("rst_req", pm_if.pm_req, 1'b0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_ir", inst, 16'h0000);
    chk("rst_alu_en", alu_en, 1'b0);
    chk("rst_halted", halted, 1'b0);

    rst_n = 1'b1;
    run   = 1'b1;

    // ALU word, immediate ack
    run_instr(16'h0140, 0, 1'b0, 1'b0);
    // Unconditional jump to 5
    run_instr(16'h8005, 0, 1'b0, 1'b0);
    // Jump-if-zero, taken then not taken
    run_instr(16'h9010, 0, 1'b1, 1'b0);
    run_instr(16'h9010, 0, 1'b0, 1'b0);
    // Jump-if-not-zero taken
    run_instr(16'hB010, 0, 1'b0, 1'b1);
    // Jump-if-carry, not taken then taken
    run_instr(16'hA020, 0, 1'b1, 1'b0);
    run_instr(16'hA020, 0, 1'b0, 1'b1);
    // Ack delayed 4 cycles
    run_instr(16'h0140, 4, 1'b0, 1'b0);
    // PC wrap from FF on a reserved NOP
    run_instr(16'h80FF, 0, 1'b0, 1'b0);
    run_instr(16'h4000, 0, 1'b0, 1'b0);
    chk("wrap_pc", exp_pc, 8'h00);
    // Long ack wait: no limit in the default build
    run_instr(16'hC123, 20, 1'b1, 1'b1);

    // Randomized stream of non-halting words
    for (int i = 0; i < 60; i++) begin
      w = 16'($urandom);
      if (w[15:10] == 6'b111111) w[10] = 1'b0;
      run_instr(w, int'($urandom_range(0, 5)), 1'($urandom), 1'($urandom));
    end

    // run dropped: current instruction retires, then sequencer idles
    run = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_req", pm_if.pm_req, 1'b0);
      chk("idle_pc", pc, exp_pc);
    end
    run = 1'b1;
    run_instr(16'h0001, 0, 1'b0, 1'b0);

    // HLT: halted, no more requests, PC frozen even with stray acks
    run_instr(16'hFC00, 0, 1'b0, 1'b0);
    pm_if.pm_ack = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("halt_halted", halted, 1'b1);
      chk("halt_req", pm_if.pm_req, 1'b0);
      chk("halt_pc", pc, exp_pc);
    end
    pm_if.pm_ack = 1'b0;

    // Reset out of HALT
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", halted, 1'b0);
    chk("rst2_pc", pc, 8'h00);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_pc  = 8'h00;
    last_ir = 16'h0000;
    run_instr(16'h0140, 0, 1'b0, 1'b0);

    // Reset mid-fetch drops pm_req immediately; later acks ignored
    @(negedge clk);
    chk("mid_req", pm_if.pm_req, 1'b1);
    chk("mid_addr", pm_if.pm_addr, 8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", pm_if.pm_req, 1'b0);
    chk("mid_rst_pc", pc, 8'h00);
    chk("mid_rst_ir", inst, 16'h0000);
    run           = 1'b0;
    pm_if.pm_ack  = 1'b1;
    pm_if.pm_data = 16'h1234;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_req", pm_if.pm_req, 1'b0);
      chk("post_rst_ir", inst, 16'h0000);
      chk("post_rst_pc", pc, 8'h00);
    end
    pm_if.pm_ack = 1'b0;
    run          = 1'b1;
    exp_pc       = 8'h00;
    last_ir      = 16'h0000;
    run_instr(16'h8042, 0, 1'b0, 1'b0);
    run_instr(16'h0003, 2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
